cic_decim_ctrl: RTL and testbench

CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

---
 rtl/cic_decim_ctrl_pkg.sv | 26 ++
 rtl/cic_decim_ctrl.sv | 128 ++++++++++++
 tb/tb_cic_decim_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_decim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cic_decim_ctrl_pkg
// Brief    : Shared types and constants for the CIC decimator controller.
// Revision : 1.0 - initial release
// ============================================================================
package cic_decim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } cic_state_t;

    localparam int DEF_STAGES = 3;
    localparam int DEF_DELAY  = 2;

    // Comb strobes needed to flush every comb delay element before output is usable
    function automatic int warmup_len(input int stages, input int delay);
        return stages * delay;
    endfunction

    localparam int WARMUP = warmup_len(DEF_STAGES, DEF_DELAY);

endpackage
`default_nettype wire

// File: rtl/cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cic_decim_ctrl
// Brief    : Sequences integrator enable, comb strobes and output valid for a
//            CIC decimator, including comb warm-up after every start.
// Revision : 1.0 - initial release
// ============================================================================
module cic_decim_ctrl
    import cic_decim_ctrl_pkg::*;
#(
    parameter int STAGES    = DEF_STAGES,
    parameter int DELAY     = DEF_DELAY,
    parameter int MAX_RATE  = 256,
    parameter int RATE_BITS = $clog2(MAX_RATE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RATE_BITS-1:0] cfg_rate,
    input  logic                 cfg_load,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 in_valid,
    output logic                 integ_en,
    output logic                 comb_valid,
    output logic                 out_valid,
    output logic [RATE_BITS-1:0] phase,
    output logic                 busy,
    output logic                 cfg_err
);

    localparam int                     c_warmup    = warmup_len(STAGES, DELAY);
    localparam int                     c_warm_bits = $clog2(c_warmup + 1);
    localparam logic [c_warm_bits-1:0] c_warm_last = c_warm_bits'(c_warmup - 1);
    localparam logic [c_warm_bits-1:0] c_warm_one  = c_warm_bits'(1);
    localparam logic [RATE_BITS-1:0]   c_max_rate  = RATE_BITS'(MAX_RATE);
    localparam logic [RATE_BITS-1:0]   c_rate_one  = RATE_BITS'(1);

    cic_state_t             r_state;
    cic_state_t             w_state_next;
    logic [RATE_BITS-1:0]   r_rate;
    logic [RATE_BITS-1:0]   r_phase;
    logic [c_warm_bits-1:0] r_warm_cnt;
    logic [STAGES-1:0]      r_shift;
    logic                   r_comb_valid;
    logic                   r_comb_tag;
    logic                   r_cfg_err;
    logic                   w_active;
    logic                   w_accept;
    logic                   w_wrap;
    logic                   w_issue;
    logic                   w_warm_done;
    logic                   w_cfg_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start && !stop) w_state_next = WARM;
            WARM:    if (stop) w_state_next = IDLE;
                     else if (w_issue && w_warm_done) w_state_next = RUN;
            RUN:     if (stop) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_active    = (r_state != IDLE);
        // A stop cycle still enables the integrators but may not launch a strobe
        w_accept    = in_valid && w_active && !stop;
        w_wrap      = (r_phase == r_rate - c_rate_one);
        w_issue     = w_accept && w_wrap;
        w_warm_done = (r_warm_cnt == c_warm_last);
        w_cfg_ok    = (r_state == IDLE) && (cfg_rate != '0) && (cfg_rate <= c_max_rate);
        integ_en    = in_valid && w_active;
        busy        = w_active || (|r_shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rate       <= c_rate_one;
            r_phase      <= '0;
            r_warm_cnt   <= '0;
            r_comb_valid <= 1'b0;
            r_comb_tag   <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_shift      <= '0;
        end else begin
            r_comb_valid <= w_issue;
            r_comb_tag   <= w_issue && (r_state == RUN);
            r_cfg_err    <= cfg_load && !w_cfg_ok;
            if (cfg_load && w_cfg_ok) begin
                r_rate <= cfg_rate;
            end
            if (r_state == IDLE) begin
                if (start && !stop) begin
                    r_phase    <= '0;
                    r_warm_cnt <= '0;
                end
            end else if (stop) begin
                r_phase <= '0;
            end else if (w_accept) begin
                r_phase <= w_wrap ? '0 : r_phase + c_rate_one;
                if (w_wrap && (r_state == WARM) && !w_warm_done) begin
                    r_warm_cnt <= r_warm_cnt + c_warm_one;
                end
            end
            // Only strobes launched from RUN travel down the output delay line
            r_shift[0] <= r_comb_valid && r_comb_tag;
            for (int i = 1; i < STAGES; i++) begin
                r_shift[i] <= r_shift[i-1];
            end
        end
    end

    assign comb_valid = r_comb_valid;
    assign out_valid  = r_shift[STAGES-1];
    assign phase      = r_phase;
    assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_decim_ctrl
// Brief    : Directed and random checks of cic_decim_ctrl against a count-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_decim_ctrl;

    localparam int STAGES    = 3;
    localparam int DELAY     = 2;
    localparam int MAX_RATE  = 256;
    localparam int RATE_BITS = 9;
    localparam int WARM_STROBES = STAGES * DELAY;

    logic                 clk;
    logic                 rst_n;
    logic [RATE_BITS-1:0] cfg_rate;
    logic                 cfg_load;
    logic                 start;
    logic                 stop;
    logic                 in_valid;
    logic                 integ_en;
    logic                 comb_valid;
    logic                 out_valid;
    logic [RATE_BITS-1:0] phase;
    logic                 busy;
    logic                 cfg_err;

    cic_decim_ctrl #(
        .STAGES    (STAGES),
        .DELAY     (DELAY),
        .MAX_RATE  (MAX_RATE),
        .RATE_BITS (RATE_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_rate   (cfg_rate),
        .cfg_load   (cfg_load),
        .start      (start),
        .stop       (stop),
        .in_valid   (in_valid),
        .integ_en   (integ_en),
        .comb_valid (comb_valid),
        .out_valid  (out_valid),
        .phase      (phase),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: everything follows from the count of samples accepted since start
    bit m_active;
    int m_rate;
    int m_n;
    int m_strobes;
    int cyc;
    bit e_ov_now;
    int ov_due[$];

    int obs_cv_cnt;
    int cv7_cyc;
    int first_ov_cyc;
    int obs_ov_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_rate    = 1;
        m_n       = 0;
        m_strobes = 0;
        e_ov_now  = 1'b0;
        ov_due.delete();
    endtask

    task automatic cycle(input bit ld, input int rate, input bit st, input bit sp, input bit iv);
        bit e_err;
        bit e_cv;
        bit ok;
        bit e_busy;
        cfg_load = ld;
        cfg_rate = RATE_BITS'(rate);
        start    = st;
        stop     = sp;
        in_valid = iv;
        #1;
        e_busy = m_active || e_ov_now || (ov_due.size() > 0 && ov_due[0] - 2 <= cyc);
        chk("integ_en", 32'(integ_en), 32'(m_active && iv));
        chk("busy", 32'(busy), 32'(e_busy));

        ok    = !m_active && rate >= 1 && rate <= MAX_RATE;
        e_err = ld && !ok;
        if (ld && ok) m_rate = rate;
        e_cv = 1'b0;
        if (!m_active) begin
            if (st && !sp) begin
                m_active  = 1'b1;
                m_n       = 0;
                m_strobes = 0;
            end
        end else if (sp) begin
            m_active = 1'b0;
            m_n      = 0;
        end else if (iv) begin
            m_n++;
            if (m_n % m_rate == 0) begin
                e_cv = 1'b1;
                m_strobes++;
                if (m_strobes > WARM_STROBES) ov_due.push_back(cyc + 1 + STAGES);
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        e_ov_now = (ov_due.size() > 0 && ov_due[0] == cyc);
        if (e_ov_now) void'(ov_due.pop_front());
        chk("comb_valid", 32'(comb_valid), 32'(e_cv));
        chk("out_valid", 32'(out_valid), 32'(e_ov_now));
        chk("phase", 32'(phase), 32'(m_n % m_rate));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));

        if (comb_valid) begin
            obs_cv_cnt++;
            if (obs_cv_cnt == WARM_STROBES + 1) cv7_cyc = cyc;
        end
        if (out_valid) begin
            obs_ov_cnt++;
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic run_iv(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1);
    endtask

    task automatic clear_obs();
        obs_cv_cnt   = 0;
        cv7_cyc      = -1;
        first_ov_cyc = -1;
        obs_ov_cnt   = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_rate = '0;
        cfg_load = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        in_valid = 1'b0;
        cyc      = 0;
        model_reset();
        clear_obs();

        #7;
        chk("rst_comb_valid", 32'(comb_valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;

        // R=4, continuous samples: six warm-up strobes, first output 3 cycles after strobe 7
        cycle(1, 4, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        clear_obs();
        run_iv(34);
        chk("r4_first_ov_latency", 32'(first_ov_cyc - cv7_cyc), 32'(STAGES));
        cycle(0, 0, 0, 1, 0);
        idle(6);

        // R=1 loaded together with start; then stop with two strobes in flight
        clear_obs();
        cycle(1, 1, 1, 0, 0);
        run_iv(10);
        chk("r1_first_ov_latency", 32'(first_ov_cyc - cv7_cyc), 32'(STAGES));
        idle(5);
        run_iv(2);
        obs_ov_cnt = 0;
        cycle(0, 0, 0, 1, 0);
        idle(7);
        chk("ov_after_stop", 32'(obs_ov_cnt), 2);

        // Rejected configurations, then R=3 with a sparse sample pattern
        cycle(1, 0, 0, 0, 0);
        cycle(1, 300, 0, 0, 0);
        cycle(1, 3, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        run_iv(22);
        cycle(1, 8, 0, 0, 1);
        run_iv(10);
        cycle(0, 0, 0, 1, 1);
        idle(6);

        // Asynchronous reset mid-RUN with strobes in flight
        cycle(1, 2, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        run_iv(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_comb_valid", 32'(comb_valid), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_phase", 32'(phase), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_integ_en", 32'(integ_en), 0);
        chk("arst_cfg_err", 32'(cfg_err), 0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        idle(4);
        cycle(0, 0, 1, 0, 0);
        run_iv(12);
        cycle(0, 0, 0, 1, 0);
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      r = 0;
            else if (sel == 1) r = int'($urandom_range(257, 300));
            else if (sel == 2) r = int'($urandom_range(5, 12));
            else               r = int'($urandom_range(1, 4));
            cycle($urandom_range(0, 19) == 0, r, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
        end
        cycle(0, 0, 0, 1, 0);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
